// File: rtl/dropout_grad_mask.sv
// dropout_grad_mask
//   Backward-pass companion to the forward dropout stage. Keep-masks from the
//   forward pass are queued in a small FIFO and replayed, in order, against the
//   gradient vectors that come back during backpropagation. Dropped lanes give
//   zero; kept lanes pass the gradient through.
//
//   Build option: DROPOUT_GRAD_SCALE_EN
//     defined   -> kept lanes are shifted left by SCALE_SHIFT with signed
//                  saturation (inverted dropout)
//     undefined -> kept lanes pass unchanged, no shifter is built
//
//   Ports
//     clk, reset          clock, asynchronous active-high reset
//     mask_valid/ready    keep-mask push handshake, mask_in bit i = lane i kept
//     grad_valid/ready    gradient vector handshake; accepting one pops a mask
//     grad_in             NEURONS lanes of WIDTH bits, lane i at [i*WIDTH +: WIDTH]
//     out_valid/ready     registered masked-gradient output handshake
//     grad_out            masked gradient, same packing as grad_in
//     mask_count          masks currently held in the FIFO

// Per-lane select/scale.
module dropout_grad_lane #(
  parameter int WIDTH       = 8,
  parameter int SCALE_SHIFT = 1
) (
  input  logic             keep_i,
  input  logic [WIDTH-1:0] grad_i,
  output logic [WIDTH-1:0] res_o
);
`ifdef DROPOUT_GRAD_SCALE_EN
  localparam int EW = WIDTH + SCALE_SHIFT;
  logic [EW-1:0]          ext, shl;
  logic [SCALE_SHIFT:0]   top;
  logic [WIDTH-1:0]       sat;

  always_comb begin
    ext = {{SCALE_SHIFT{grad_i[WIDTH-1]}}, grad_i};
    shl = ext << SCALE_SHIFT;
    // Result fits only if every bit shifted past the sign matches the sign.
    top = shl[EW-1:WIDTH-1];
    if (top == '0 || top == '1) sat = shl[WIDTH-1:0];
    else if (grad_i[WIDTH-1])   sat = {1'b1, {(WIDTH-1){1'b0}}};
    else                        sat = {1'b0, {(WIDTH-1){1'b1}}};
  end

  assign res_o = keep_i ? sat : '0;
`else
  assign res_o = keep_i ? grad_i : '0;
`endif
endmodule

module dropout_grad_mask #(
  parameter int NEURONS     = 8,
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SCALE_SHIFT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mask_valid,
  output logic                       mask_ready,
  input  logic [NEURONS-1:0]         mask_in,
  input  logic                       grad_valid,
  output logic                       grad_ready,
  input  logic [NEURONS*WIDTH-1:0]   grad_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NEURONS*WIDTH-1:0]   grad_out,
  output logic [$clog2(DEPTH):0]     mask_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [NEURONS-1:0]              mem_q [DEPTH];
  logic [PW-1:0]                   wptr_q, rptr_q;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            out_valid_q, out_valid_d;
  logic [NEURONS-1:0][WIDTH-1:0]   grad_out_q, lane_res, grad_lanes;
  logic [NEURONS-1:0]              head;
  logic                            push, pop;

  assign grad_lanes = grad_in;
  assign head       = mem_q[rptr_q];

  // Full-ness is judged on the registered count only: a full FIFO refuses a
  // mask even if a pop happens in the same cycle.
  assign mask_ready = (cnt_q < CW'(DEPTH));
  assign grad_ready = (cnt_q != '0) && (!out_valid_q || out_ready);
  assign push       = mask_valid && mask_ready;
  assign pop        = grad_valid && grad_ready;

  for (genvar i = 0; i < NEURONS; i++) begin : g_lane
    dropout_grad_lane #(.WIDTH(WIDTH), .SCALE_SHIFT(SCALE_SHIFT)) u_lane (
      .keep_i (head[i]),
      .grad_i (grad_lanes[i]),
      .res_o  (lane_res[i])
    );
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    out_valid_d = out_valid_q;
    if (pop)            out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  // Mask storage carries no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= mask_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      grad_out_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop) begin
        rptr_q     <= rptr_q + PW'(1);
        grad_out_q <= lane_res;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign grad_out   = grad_out_q;
  assign mask_count = cnt_q;
endmodule

// File: tb/tb_dropout_grad_mask.sv
module tb_dropout_grad_mask;
  localparam int NEURONS     = 8;
  localparam int WIDTH       = 8;
  localparam int DEPTH       = 4;
  localparam int SCALE_SHIFT = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        mask_valid, mask_ready;
  logic [7:0]  mask_in;
  logic        grad_valid, grad_ready;
  logic [63:0] grad_in;
  logic        out_valid, out_ready;
  logic [63:0] grad_out;
  logic [2:0]  mask_count;

  int vectors = 0;
  int errs    = 0;

  // reference state: queued masks and the output register contents
  logic [7:0]  mq[$];
  logic        m_ov;
  logic [63:0] m_go;

  always #5 clk = ~clk;

  dropout_grad_mask #(.NEURONS(NEURONS), .WIDTH(WIDTH), .DEPTH(DEPTH),
                      .SCALE_SHIFT(SCALE_SHIFT)) dut (
    .clk(clk), .reset(reset),
    .mask_valid(mask_valid), .mask_ready(mask_ready), .mask_in(mask_in),
    .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_in(grad_in),
    .out_valid(out_valid), .out_ready(out_ready), .grad_out(grad_out),
    .mask_count(mask_count)
  );

  function automatic logic [7:0] lanef(logic k, logic [7:0] g);
    int v;
    if (!k) return 8'h00;
    v = $signed(g);
`ifdef DROPOUT_GRAD_SCALE_EN
    v = v * (1 << SCALE_SHIFT);
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
`endif
    return v[7:0];
  endfunction

  function automatic logic [63:0] apply(logic [7:0] m, logic [63:0] g);
    logic [63:0] r;
    for (int i = 0; i < NEURONS; i++) r[i*8 +: 8] = lanef(m[i], g[i*8 +: 8]);
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic mv, logic [7:0] m, logic gv, logic [63:0] g, logic ordy);
    mask_valid = mv; mask_in = m; grad_valid = gv; grad_in = g; out_ready = ordy;
  endtask

  // One clock: check handshakes against the model, step model and DUT, check outputs.
  task automatic cyc();
    bit push, pop, gr;
    #1;
    gr = (mq.size() != 0) && (!m_ov || out_ready);
    chk("mask_ready", mask_ready, mq.size() < DEPTH);
    chk("grad_ready", grad_ready, gr);
    push = mask_valid && (mq.size() < DEPTH);
    pop  = grad_valid && gr;
    if (pop) begin
      m_go = apply(mq[0], grad_in);
      void'(mq.pop_front());
      m_ov = 1'b1;
    end else if (out_ready) m_ov = 1'b0;
    if (push) mq.push_back(mask_in);
    @(posedge clk); #1;
    chk("out_valid", out_valid, m_ov);
    chk("grad_out", grad_out, m_go);
    chk("mask_count", mask_count, mq.size());
  endtask

  initial begin
    m_ov = 1'b0; m_go = '0;
    reset = 1'b1;
    drive(0, 8'h00, 0, 64'h0, 1);
    #3;
    chk("rst_mask_ready", mask_ready, 1);
    chk("rst_grad_ready", grad_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_grad_out", grad_out, 0);
    chk("rst_mask_count", mask_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // basic mask
    drive(1, 8'hA5, 0, 64'h0, 1); cyc();
    drive(0, 8'h00, 1, {8{8'h10}}, 1); cyc();
`ifdef DROPOUT_GRAD_SCALE_EN
    chk("basic_lit", grad_out, 64'h2000_2000_0020_0020);
`else
    chk("basic_lit", grad_out, 64'h1000_1000_0010_0010);
`endif
    chk("basic_vld", out_valid, 1);
    drive(0, 8'h00, 0, 64'h0, 1); cyc();

    // fill the FIFO, then a refused fifth push
    drive(1, 8'hFF, 0, 64'h0, 1); cyc();
    drive(1, 8'h00, 0, 64'h0, 1); cyc();
    drive(1, 8'h0F, 0, 64'h0, 1); cyc();
    drive(1, 8'hF0, 0, 64'h0, 1); cyc();
    chk("full_count", mask_count, 4);
    drive(1, 8'h77, 0, 64'h0, 1); cyc();
    chk("full_count2", mask_count, 4);
    drive(0, 8'h00, 1, {8{8'h01}}, 1);
    for (int k = 0; k < 4; k++) cyc();
    drive(0, 8'h00, 0, 64'h0, 1); cyc();

    // saturation
    drive(1, 8'hFF, 0, 64'h0, 1); cyc();
    drive(0, 8'h00, 1, 64'h0000_0000_C03F_B050, 1); cyc();
`ifdef DROPOUT_GRAD_SCALE_EN
    chk("sat_lit", grad_out, 64'h0000_0000_807E_807F);
`else
    chk("sat_lit", grad_out, 64'h0000_0000_C03F_B050);
`endif
    drive(0, 8'h00, 0, 64'h0, 1); cyc();

    // backpressure
    drive(1, 8'h3C, 0, 64'h0, 1); cyc();
    drive(1, 8'hC3, 1, 64'h1122_3344_5566_7788, 0); cyc();
    drive(0, 8'h00, 1, 64'h99AA_BBCC_DDEE_FF01, 0);
    for (int k = 0; k < 5; k++) cyc();
    drive(0, 8'h00, 1, 64'h99AA_BBCC_DDEE_FF01, 1); cyc();
    drive(0, 8'h00, 0, 64'h0, 1); cyc();

    // empty, then push and pop together
    drive(0, 8'h00, 1, {8{8'h7F}}, 1); cyc(); cyc();
    drive(1, 8'h11, 0, 64'h0, 1); cyc();
    drive(1, 8'h22, 1, {8{8'h05}}, 1); cyc();
    chk("simul_count", mask_count, 1);
    drive(0, 8'h00, 1, {8{8'h05}}, 1); cyc();
    drive(0, 8'h00, 0, 64'h0, 1); cyc();

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      drive($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1),
            {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      cyc();
    end

    // reset mid-stream with 3 masks stored and a pending result
    drive(0, 8'h00, 0, 64'h0, 1); cyc(); cyc();
    while (mq.size() != 0) begin drive(0, 8'h00, 1, 64'h0, 1); cyc(); end
    drive(0, 8'h00, 0, 64'h0, 1); cyc();
    for (int k = 0; k < 4; k++) begin drive(1, 8'h81 + 8'(k), 0, 64'h0, 1); cyc(); end
    drive(0, 8'h00, 1, {8{8'h33}}, 0); cyc();
    chk("pre_rst_count", mask_count, 3);
    chk("pre_rst_vld", out_valid, 1);
    drive(0, 8'h00, 0, 64'h0, 0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_mask_ready", mask_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_grad_out", grad_out, 0);
    chk("mid_rst_mask_count", mask_count, 0);
    mq.delete(); m_ov = 1'b0; m_go = '0;
    #2 reset = 1'b0;
    drive(0, 8'h00, 1, {8{8'h44}}, 1); cyc();
    drive(1, 8'h0F, 1, {8{8'h44}}, 1); cyc();
    drive(0, 8'h00, 1, {8{8'h44}}, 1); cyc();
    drive(0, 8'h00, 0, 64'h0, 1); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/dropout_grad_mask.md
# dropout_grad_mask

Backward-pass companion to the forward dropout stage. It captures each 8-bit keep-mask that the forward stage applies to a sample, buffers the masks in order, and replays them against the gradient vectors returned during backpropagation. Dropped neurons get a zero gradient. Kept neurons pass their gradient through, optionally scaled for inverted dropout. The block sits between the layer's error-propagation path and the preceding layer's gradient input.

## Interface
- NEURONS, 8, lanes per vector; fixed at 8 in this revision.
- WIDTH, 8, signed two's-complement bits per gradient lane.
- DEPTH, 4, mask FIFO entries; power of 2, ≥2.
- SCALE_SHIFT, 1, left-shift applied to kept gradients when scaling is compiled in (1 means ×2, i.e. p=0.5).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- mask_valid  in  1  forward stage offers a keep-mask
- mask_ready  out  1  FIFO can accept a mask
- mask_in  in  NEURONS  bit i = 1 means neuron i was kept
- grad_valid  in  1  gradient vector offered
- grad_ready  out  1  gradient vector accepted this cycle
- grad_in  in  NEURONS*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
- out_valid  out  1  masked gradient available
- out_ready  in  1  downstream accepts
- grad_out  out  NEURONS*WIDTH  masked gradient, same packing
- mask_count  out  $clog2(DEPTH)+1  masks currently stored

## Operation
- **Mask FIFO.** Circular buffer with write and read pointers, each $clog2(DEPTH) bits wide, plus a count.
  - Push on mask_valid && mask_ready.
  - mask_ready = (count < DEPTH). It does not depend on a same-cycle pop, so a full FIFO never accepts a mask.
- **Pop and apply.** A pop happens on grad_valid && grad_ready.
  - grad_ready = (count != 0) && (!out_valid || out_ready).
  - There is no bypass: a mask pushed in cycle N is first usable in cycle N+1.
- **Lane function.** For each lane i, using the head mask:
  - mask bit = 0 → result 0.
  - mask bit = 1 → grad_in lane i, or its scaled value (see Configuration).
- **Simultaneous push and pop.** Both take effect; count is unchanged and the pointers each advance by 1 modulo DEPTH.
- **Output register.** Output is a single register stage.
  - Loaded on pop: out_valid ← 1.
  - Cleared when out_valid && out_ready with no new pop.
  - While out_valid && !out_ready, grad_out and out_valid hold stable.
- **Ordering.** Strict FIFO; gradient k is paired with the k-th mask pushed since reset.
- **Gradient with no mask.** grad_valid while count = 0 is not accepted (grad_ready = 0) and is not an error.

## Timing
- Reset values: mask_ready = 1, grad_ready = 0, out_valid = 0, grad_out = 0, mask_count = 0, both pointers = 0.
- Reset mid-operation discards all stored masks and any pending output immediately, because it is asynchronous.
- Latency: accepted gradient in cycle N appears on grad_out with out_valid = 1 at cycle N+1.
- Throughput: one vector per cycle when out_ready = 1 and count > 0.
- mask_count updates one cycle after the push or pop edge. It equals the number of accepted pushes minus accepted pops.
- Pointer wrap: after entry DEPTH-1 the pointer returns to 0; the FIFO is full when count = DEPTH.

## Configuration
- Macro: DROPOUT_GRAD_SCALE_EN.
- **Defined:** kept lanes output grad_in lane << SCALE_SHIFT with signed saturation.
  - Positive overflow → 2^(WIDTH-1)-1 (0x7F).
  - Negative overflow → -2^(WIDTH-1) (0x80).
- **Undefined:** kept lanes pass grad_in unchanged; no shifter or saturation logic is built. SCALE_SHIFT is ignored.

## Test plan
- **Basic mask:** push mask 0xA5, then gradient with all lanes = 0x10 → one cycle later out_valid = 1.
  - With scaling: lanes 0, 2, 5, 7 = 0x20 and the rest 0x00.
  - Without scaling: lanes 0, 2, 5, 7 = 0x10 and the rest 0x00.
- **FIFO order and full:** push 0xFF, 0x00, 0x0F, 0xF0 (DEPTH = 4) → mask_count = 4 and mask_ready = 0; a fifth push is refused.
  - Then four gradients of all 0x01 → outputs masked by 0xFF, 0x00, 0x0F, 0xF0 in that order.
- **Saturation (DROPOUT_GRAD_SCALE_EN):** mask 0xFF, lanes 0x50, 0xB0, 0x3F, 0xC0 (rest 0) → 0x7F, 0x80, 0x7E, 0x80.
- **Backpressure:** out_ready = 0 with one result pending → grad_ready = 0 and grad_out held stable for 5 cycles.
  - Raise out_ready → result consumed, and the next gradient is accepted in the same cycle.
- **Empty and simultaneous:** with count = 0, grad_valid = 1 → grad_ready = 0.
  - With count = 1, push and pop in the same cycle → mask_count stays 1 and the popped mask is the older one.
- **Reset mid-stream:** 3 masks stored and out_valid = 1, assert reset between clock edges → all outputs take their reset values immediately.
  - After release, a gradient is refused until a new mask is pushed.
